// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and helpers for the timing generator,
// vga_controller and the renderer.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Inclusive counter range over which a sync pulse is asserted.
    typedef struct packed {
        coord_t first;
        coord_t last;
    } sync_span_t;

    function automatic sync_span_t sync_span(input int visible, input int front, input int width);
        sync_span_t span;
        span.first = coord_t'(visible + front);
        span.last  = coord_t'(visible + front + width - 1);
        return span;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that clears every stage to RESET_VAL; depth 0 is a
// plain wire.
module sync_delay_line
    import vga_pkg::*;
#(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ctrl;
            assign w_unused_ctrl = i_clk ^ i_reset;
            assign o_data        = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, undelayed coordinate strobes and
// sync/video_on delayed to line up with the renderer's registered RGB.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE   = VGA_H_VISIBLE,
    parameter int   H_FRONT     = VGA_H_FRONT,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   V_VISIBLE   = VGA_V_VISIBLE,
    parameter int   V_FRONT     = VGA_V_FRONT,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 1
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_active,
    output logic       line_start,
    output logic       frame_start,
    output logic       h_sync,
    output logic       v_sync,
    output logic       video_on
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t     H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t     V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t     H_VIS     = coord_t'(H_VISIBLE);
    localparam coord_t     V_VIS     = coord_t'(V_VISIBLE);
    localparam sync_span_t H_SPAN    = sync_span(H_VISIBLE, H_FRONT, H_SYNC);
    localparam sync_span_t V_SPAN    = sync_span(V_VISIBLE, V_FRONT, V_SYNC);
    localparam logic       SYNC_IDLE = ~SYNC_ACTIVE;

    generate
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4 || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_cfg_error
            $error("vga_timing_gen: PIPE_DELAY must be 0..4 and H_TOTAL/V_TOTAL must fit in 10 bits");
        end
    endgenerate

    coord_t     r_h_count;
    coord_t     r_v_count;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_in_h_sync;
    logic       w_in_v_sync;
    logic       w_active_raw;
    logic       w_h_sync_raw;
    logic       w_v_sync_raw;
    logic [2:0] w_delay_in;
    logic [2:0] w_delay_out;

    assign w_h_wrap = (r_h_count == H_LAST);
    assign w_v_wrap = (r_v_count == V_LAST);

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (w_h_wrap) begin
            r_h_count <= '0;
            r_v_count <= w_v_wrap ? '0 : r_v_count + coord_t'(1);
        end else begin
            r_h_count <= r_h_count + coord_t'(1);
        end
    end

    assign w_in_h_sync = (r_h_count >= H_SPAN.first) && (r_h_count <= H_SPAN.last);
    assign w_in_v_sync = (r_v_count >= V_SPAN.first) && (r_v_count <= V_SPAN.last);

    // Raw decodes are held inactive during reset so a zero-depth delay line still
    // presents idle sync and blank video while the counters are being cleared.
    assign w_active_raw = ~reset && (r_h_count < H_VIS) && (r_v_count < V_VIS);
    assign w_h_sync_raw = (~reset && w_in_h_sync) ? SYNC_ACTIVE : SYNC_IDLE;
    assign w_v_sync_raw = (~reset && w_in_v_sync) ? SYNC_ACTIVE : SYNC_IDLE;

    assign pixel_x      = r_h_count;
    assign pixel_y      = r_v_count;
    assign pixel_active = w_active_raw;
    assign line_start   = ~reset && (r_h_count == '0);
    assign frame_start  = ~reset && (r_h_count == '0) && (r_v_count == '0);

    assign w_delay_in = {w_h_sync_raw, w_v_sync_raw, w_active_raw};

    sync_delay_line #(
        .DEPTH     (PIPE_DELAY),
        .WIDTH     (3),
        .RESET_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
    ) u_sync_delay (
        .i_clk   (clk_25mhz),
        .i_reset (reset),
        .i_data  (w_delay_in),
        .o_data  (w_delay_out)
    );

    assign h_sync   = w_delay_out[2];
    assign v_sync   = w_delay_out[1];
    assign video_on = w_delay_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing (delay 1, active-low), full-size pass-through
// (delay 0, active-high) and a tiny raster (delay 2) for frame-level corners.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a;
    logic rst_s;

    logic [9:0] a_x, a_y, z_x, z_y, s_x, s_y;
    logic a_act, a_ls, a_fs, a_hs, a_vs, a_vo;
    logic z_act, z_ls, z_fs, z_hs, z_vs, z_vo;
    logic s_act, s_ls, s_fs, s_hs, s_vs, s_vo;

    vga_timing_gen dut_a (
        .clk_25mhz(clk), .reset(rst_a), .pixel_x(a_x), .pixel_y(a_y),
        .pixel_active(a_act), .line_start(a_ls), .frame_start(a_fs),
        .h_sync(a_hs), .v_sync(a_vs), .video_on(a_vo)
    );

    vga_timing_gen #(.SYNC_ACTIVE(1'b1), .PIPE_DELAY(0)) dut_z (
        .clk_25mhz(clk), .reset(rst_a), .pixel_x(z_x), .pixel_y(z_y),
        .pixel_active(z_act), .line_start(z_ls), .frame_start(z_fs),
        .h_sync(z_hs), .v_sync(z_vs), .video_on(z_vo)
    );

    // 14 clocks/line (h sync at 10..11), 8 lines/frame (v sync on lines 5..6).
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(2)
    ) dut_s (
        .clk_25mhz(clk), .reset(rst_s), .pixel_x(s_x), .pixel_y(s_y),
        .pixel_active(s_act), .line_start(s_ls), .frame_start(s_fs),
        .h_sync(s_hs), .v_sync(s_vs), .video_on(s_vo)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int   k;
        int   x;
        int   y;
        logic act;
        logic ls;
        logic fs;
        logic hs;
        logic vs;
        logic vo;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int idx, hs_low, vo_hi, ls_cnt, ls_bad_gap, last_ls;
    int z_hs_bad, z_vo_bad, z_hs_hi, z_vs_hi;
    int s_fs_cnt, s_vs_low, s_vs_first, s_vo_hi, waited;
    int s_fs_k [3];

    initial begin
        // k = clock edges since reset release; delayed outputs lag raw by one edge.
        vecs[0]  = '{k:0,    x:0,   y:0, act:1, ls:1, fs:1, hs:1, vs:1, vo:0};
        vecs[1]  = '{k:1,    x:1,   y:0, act:1, ls:0, fs:0, hs:1, vs:1, vo:1};
        vecs[2]  = '{k:639,  x:639, y:0, act:1, ls:0, fs:0, hs:1, vs:1, vo:1};
        vecs[3]  = '{k:640,  x:640, y:0, act:0, ls:0, fs:0, hs:1, vs:1, vo:1};
        vecs[4]  = '{k:641,  x:641, y:0, act:0, ls:0, fs:0, hs:1, vs:1, vo:0};
        vecs[5]  = '{k:656,  x:656, y:0, act:0, ls:0, fs:0, hs:1, vs:1, vo:0};
        vecs[6]  = '{k:657,  x:657, y:0, act:0, ls:0, fs:0, hs:0, vs:1, vo:0};
        vecs[7]  = '{k:752,  x:752, y:0, act:0, ls:0, fs:0, hs:0, vs:1, vo:0};
        vecs[8]  = '{k:753,  x:753, y:0, act:0, ls:0, fs:0, hs:1, vs:1, vo:0};
        vecs[9]  = '{k:799,  x:799, y:0, act:0, ls:0, fs:0, hs:1, vs:1, vo:0};
        vecs[10] = '{k:800,  x:0,   y:1, act:1, ls:1, fs:0, hs:1, vs:1, vo:0};
        vecs[11] = '{k:801,  x:1,   y:1, act:1, ls:0, fs:0, hs:1, vs:1, vo:1};
        vecs[12] = '{k:1456, x:656, y:1, act:0, ls:0, fs:0, hs:1, vs:1, vo:0};
        vecs[13] = '{k:1457, x:657, y:1, act:0, ls:0, fs:0, hs:0, vs:1, vo:0};
        vecs[14] = '{k:1600, x:0,   y:2, act:1, ls:1, fs:0, hs:1, vs:1, vo:0};

        rst_a = 1'b1;
        rst_s = 1'b1;
        repeat (5) tick();

        check("rst_a_hs", int'(a_hs), 1);
        check("rst_a_vs", int'(a_vs), 1);
        check("rst_a_vo", int'(a_vo), 0);
        check("rst_a_x", int'(a_x), 0);
        check("rst_a_y", int'(a_y), 0);
        check("rst_a_fs", int'(a_fs), 0);
        check("rst_a_ls", int'(a_ls), 0);
        check("rst_a_act", int'(a_act), 0);
        check("rst_z_hs", int'(z_hs), 0);
        check("rst_z_vs", int'(z_vs), 0);
        check("rst_z_vo", int'(z_vo), 0);
        check("rst_s_hs", int'(s_hs), 1);

        rst_a = 1'b0;
        rst_s = 1'b0;
        #1;

        idx = 0; hs_low = 0; vo_hi = 0; ls_cnt = 0; ls_bad_gap = 0; last_ls = -1;
        z_hs_bad = 0; z_vo_bad = 0; z_hs_hi = 0; z_vs_hi = 0;
        s_fs_cnt = 0; s_vs_low = 0; s_vs_first = -1; s_vo_hi = 0;

        for (int k = 0; k <= 1700; k++) begin
            if (idx < NV && vecs[idx].k == k) begin
                check($sformatf("a_k%0d_x", k), int'(a_x), vecs[idx].x);
                check($sformatf("a_k%0d_y", k), int'(a_y), vecs[idx].y);
                check($sformatf("a_k%0d_act", k), int'(a_act), int'(vecs[idx].act));
                check($sformatf("a_k%0d_ls", k), int'(a_ls), int'(vecs[idx].ls));
                check($sformatf("a_k%0d_fs", k), int'(a_fs), int'(vecs[idx].fs));
                check($sformatf("a_k%0d_hs", k), int'(a_hs), int'(vecs[idx].hs));
                check($sformatf("a_k%0d_vs", k), int'(a_vs), int'(vecs[idx].vs));
                check($sformatf("a_k%0d_vo", k), int'(a_vo), int'(vecs[idx].vo));
                idx++;
            end
            if (k < 1600 && !a_hs) hs_low++;
            if (k < 800 && a_vo) vo_hi++;
            if (a_ls) begin
                ls_cnt++;
                if (last_ls >= 0 && k - last_ls != 800) ls_bad_gap++;
                last_ls = k;
            end

            if (z_hs !== ((z_x >= 10'd656) && (z_x <= 10'd751))) z_hs_bad++;
            if (z_vo !== z_act) z_vo_bad++;
            if (k < 1600 && z_hs) z_hs_hi++;
            if (z_vs) z_vs_hi++;

            if (s_fs && s_fs_cnt < 3) begin
                s_fs_k[s_fs_cnt] = k;
                s_fs_cnt++;
            end
            if (k >= 112 && k < 224) begin
                if (!s_vs) begin
                    s_vs_low++;
                    if (s_vs_first < 0) s_vs_first = k;
                end
                if (s_vo) s_vo_hi++;
            end
            case (k)
                0: check("s_k0_vo", int'(s_vo), 0);
                1: check("s_k1_vo", int'(s_vo), 0);
                2: check("s_k2_vo", int'(s_vo), 1);
                8: begin
                    check("s_k8_x", int'(s_x), 8);
                    check("s_k8_act", int'(s_act), 0);
                end
                13: check("s_k13_xy", int'({s_x, s_y}), int'({10'd13, 10'd0}));
                14: begin
                    check("s_k14_xy", int'({s_x, s_y}), int'({10'd0, 10'd1}));
                    check("s_k14_ls", int'(s_ls), 1);
                end
                56: begin
                    check("s_k56_xy", int'({s_x, s_y}), int'({10'd0, 10'd4}));
                    check("s_k56_act", int'(s_act), 0);
                end
                111: check("s_k111_xy", int'({s_x, s_y}), int'({10'd13, 10'd7}));
                112: begin
                    check("s_k112_xy", int'({s_x, s_y}), int'({10'd0, 10'd0}));
                    check("s_k112_fs", int'(s_fs), 1);
                end
                default: ;
            endcase
            tick();
        end

        check("a_vectors_seen", idx, NV);
        check("a_hs_low_2lines", hs_low, 192);
        check("a_vo_hi_line0", vo_hi, 640);
        check("a_ls_count", ls_cnt, 3);
        check("a_ls_bad_gap", ls_bad_gap, 0);
        check("z_hs_vs_x_bad", z_hs_bad, 0);
        check("z_vo_vs_act_bad", z_vo_bad, 0);
        check("z_hs_hi_2lines", z_hs_hi, 192);
        check("z_vs_hi", z_vs_hi, 0);
        check("s_fs_count", s_fs_cnt, 3);
        check("s_fs_k0", s_fs_k[0], 0);
        check("s_fs_k1", s_fs_k[1], 112);
        check("s_fs_k2", s_fs_k[2], 224);
        check("s_vs_low_frame", s_vs_low, 28);
        check("s_vs_first_low", s_vs_first, 184);
        check("s_vo_hi_frame", s_vo_hi, 32);

        // Mid-line reset on the full-size raster while video is on.
        waited = 0;
        while (a_x != 10'd300 && waited < 900) begin
            tick();
            waited++;
        end
        check("a_reach_x300", int'(a_x), 300);
        check("a_pre_rst_y", int'(a_y), 2);
        check("a_pre_rst_vo", int'(a_vo), 1);
        rst_a = 1'b1;
        #1;
        check("a_in_rst_act", int'(a_act), 0);
        check("a_in_rst_ls", int'(a_ls), 0);
        tick();
        rst_a = 1'b0;
        #1;
        check("a_post_rst_xy", int'({a_x, a_y}), 0);
        check("a_post_rst_fs", int'(a_fs), 1);
        check("a_post_rst_vo", int'(a_vo), 0);
        check("a_post_rst_hs", int'(a_hs), 1);
        tick();
        check("a_post_rst1_vo", int'(a_vo), 1);
        check("a_post_rst1_x", int'(a_x), 1);

        // Reset in the middle of a delayed h sync pulse must cut it.
        waited = 0;
        while (s_x != 10'd13 && waited < 20) begin
            tick();
            waited++;
        end
        check("s_reach_x13", int'(s_x), 13);
        check("s_pre_rst_hs", int'(s_hs), 0);
        rst_s = 1'b1;
        tick();
        check("s_rst_hs_cut", int'(s_hs), 1);
        check("s_rst_xy", int'({s_x, s_y}), 0);
        check("s_rst_fs", int'(s_fs), 0);
        check("s_rst_vo", int'(s_vo), 0);
        rst_s = 1'b0;
        #1;
        check("s_rel0_fs", int'(s_fs), 1);
        check("s_rel0_vo", int'(s_vo), 0);
        tick();
        check("s_rel1_vo", int'(s_vo), 0);
        check("s_rel1_hs", int'(s_hs), 1);
        tick();
        check("s_rel2_vo", int'(s_vo), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
